// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences the iterative unsigned multiplier for MULT/MULTU, owns HI/LO,
// executes MTHI/MTLO and drives the pipeline stall.
module mdu_ctrl #(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_busy,
    input  logic [63:0] mul_result
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, WRITE} state_t;
    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic        mul_start_q, mul_start_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod;
    logic        timeout;
    // 0x80000000 negates to itself, which is already the correct unsigned magnitude
    assign abs_a    = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign abs_b    = op_b[31] ? (~op_b + 32'd1) : op_b;
    assign prod     = neg_q ? (~mul_result + 64'd1) : mul_result;
    assign timeout  = cnt_q == CNT_LAST;
    assign op_ready = state_q == IDLE;
    assign busy     = ~op_ready;
    assign done     = state_q == WRITE;
    assign err      = err_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mul_start = mul_start_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        err_d       = err_q;
        mul_start_d = mul_start_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            IDLE: if (op_valid) begin
                if (op_code[1]) begin
                    hi_d = op_code[0] ? hi_q : op_a;
                    lo_d = op_code[0] ? op_a : lo_q;
                end else begin
                    mul_a_d     = op_code[0] ? op_a : abs_a;
                    mul_b_d     = op_code[0] ? op_b : abs_b;
                    neg_d       = ~op_code[0] & (op_a[31] ^ op_b[31]);
                    err_d       = 1'b0;
                    cnt_d       = 7'd0;
                    mul_start_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                mul_start_d = 1'b0;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + 7'd1;
                if (mul_busy) state_d = WAIT_DONE;
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 7'd1;
                if (!mul_busy) begin
                    {hi_d, lo_d} = prod;
                    state_d      = WRITE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            mul_start_q <= mul_start_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a behavioural 32-cycle multiplier
// and a queue of expected {hi,lo} results popped on each done pulse.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_ready, busy, done, err;
    logic [31:0] hi, lo;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_busy;
    logic [63:0] mul_result;
    logic [5:0]  mcnt;
    logic        mul_dead;
    int          passed = 0, fails = 0, total = 0;
    int          start_cnt = 0, done_cnt = 0;
    logic [63:0] sb[$];

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, MTHI = 2'b10, MTLO = 2'b11;

    mdu_ctrl dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy), .done(done),
        .err(err), .hi(hi), .lo(lo), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_busy(mul_busy), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier: busy for 32 cycles after sampling a start pulse; never responds when mul_dead
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_busy   <= 1'b0;
            mcnt       <= 6'd0;
            mul_result <= 64'd0;
        end else if (mul_start && !mul_dead) begin
            mul_busy   <= 1'b1;
            mcnt       <= 6'd32;
            mul_result <= {32'd0, mul_a} * {32'd0, mul_b};
        end else if (mul_busy) begin
            mcnt     <= mcnt - 6'd1;
            mul_busy <= mcnt != 6'd1;
        end
    end

    always @(posedge clk) begin
        if (mul_start) start_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_;
        sa  = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        return (op == MULTU) ? ({32'd0, a} * {32'd0, b}) : 64'(sa * sb_);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", op_ready, 1);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        if (!op[1]) sb.push_back(ref_mul(op, a, b));
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        logic busy_ok = 1'b1;
        logic [63:0] exp;
        while (!done && n < 200) begin
            busy_ok &= busy;
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_until_done"}, busy_ok, 1);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
        else begin
            exp = sb.pop_front();
            chk({tag, "_hi"}, hi, exp[63:32]);
            chk({tag, "_lo"}, lo, exp[31:0]);
        end
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int s, d, n;
        resetn   = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'b00;
        op_a     = 32'd0;
        op_b     = 32'd0;
        mul_dead = 1'b0;
        #3;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        s = start_cnt;
        d = done_cnt;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max");
        chk("multu_max_hi_const", hi, 32'hFFFFFFFE);
        chk("multu_max_lo_const", lo, 32'h00000001);
        chk("multu_max_start_cycles", 64'(start_cnt - s), 1);
        chk("multu_max_done_cycles", 64'(done_cnt - d), 1);

        issue(MULT, 32'hFFFFFFFD, 32'h00000007);
        wait_done("mult_neg");
        chk("mult_neg_lo_const", lo, 32'hFFFFFFEB);
        issue(MULT, 32'h80000000, 32'h80000000);
        wait_done("mult_min");
        chk("mult_min_hi_const", hi, 32'h40000000);
        issue(MULT, 32'h00000000, 32'hFFFFFFFF);
        wait_done("mult_zero");

        d = done_cnt;
        op_valid = 1'b1;
        op_code  = MTHI;
        op_a     = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_ready", op_ready, 1);
        op_code = MTLO;
        op_a    = 32'h9ABCDEF0;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        chk("mtlo_ready", op_ready, 1);
        repeat (2) @(negedge clk);
        chk("mthi_mtlo_no_done", 64'(done_cnt - d), 0);

        issue(MULTU, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        op_valid = 1'b1;
        op_code  = MTHI;
        op_a     = 32'hDEADBEEF;
        wait_done("ignore_mthi");
        repeat (2) @(negedge clk);
        chk("ignore_mthi_hi_after", hi, 0);

        mul_dead = 1'b1;
        d = done_cnt;
        issue(MULTU, 32'd9, 32'd9);
        n = 0;
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        sb.delete();
        chk("timeout_busy_cycles", 64'(n), 81);
        chk("timeout_err", err, 1);
        chk("timeout_hi_kept", hi, 0);
        chk("timeout_lo_kept", lo, 32'h0000000F);
        chk("timeout_no_done", 64'(done_cnt - d), 0);
        mul_dead = 1'b0;
        issue(MULTU, 32'd2, 32'd2);
        chk("err_cleared", err, 0);
        wait_done("after_timeout");
        chk("after_timeout_lo", lo, 4);

        op_valid = 1'b1;
        op_code  = MTHI;
        op_a     = 32'hCAFEF00D;
        @(negedge clk);
        op_valid = 1'b0;
        issue(MULTU, 32'd100, 32'd100);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_ready", op_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_start", mul_start, 0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(MULTU, 32'd6, 32'd7);
        wait_done("post_rst");
        chk("post_rst_lo", lo, 42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
